// File: rtl/game_pkg.sv
// Shared definitions for the scrolling-barrier game: FSM encodings and the
// per-level speed table consumed by the barrier and ball datapaths.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Power-on / new-game configuration
  localparam logic [3:0] BARRIER_SPEED = 4'd4;
  localparam logic [3:0] MAX_SPEED     = 4'd7;

  // Difficulty table, one entry per level
  localparam logic [3:0] BARRIER_SPEED_L0 = 4'd4;
  localparam logic [3:0] BARRIER_SPEED_L1 = 4'd5;
  localparam logic [3:0] BARRIER_SPEED_L2 = 4'd6;
  localparam logic [3:0] BARRIER_SPEED_L3 = 4'd8;
  localparam logic [3:0] MAX_SPEED_L0     = 4'd7;
  localparam logic [3:0] MAX_SPEED_L1     = 4'd7;
  localparam logic [3:0] MAX_SPEED_L2     = 4'd9;
  localparam logic [3:0] MAX_SPEED_L3     = 4'd9;

  function automatic logic [3:0] barrier_speed_for(input logic [1:0] lvl);
    logic [3:0] spd;
    case (lvl)
      2'd0:    spd = BARRIER_SPEED_L0;
      2'd1:    spd = BARRIER_SPEED_L1;
      2'd2:    spd = BARRIER_SPEED_L2;
      2'd3:    spd = BARRIER_SPEED_L3;
      default: spd = BARRIER_SPEED;
    endcase
    return spd;
  endfunction

  function automatic logic [3:0] max_speed_for(input logic [1:0] lvl);
    logic [3:0] spd;
    case (lvl)
      2'd0:    spd = MAX_SPEED_L0;
      2'd1:    spd = MAX_SPEED_L1;
      2'd2:    spd = MAX_SPEED_L2;
      2'd3:    spd = MAX_SPEED_L3;
      default: spd = MAX_SPEED;
    endcase
    return spd;
  endfunction

endpackage

// File: rtl/game_speed_scheduler_frame_tick_gen.sv
// Frame divider: counts 0..TICK_DIV-1 while running, freezes while held and
// returns to 0 when cleared. tick is high in the cycle the count wraps; the
// caller registers it so the strobe it drives stays glitch-free.
module frame_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic hold,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and wrap detection; run beats hold beats clear
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = {CW{1'b0}};
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (clear) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_speed_scheduler.sv
// Play sequencer: game FSM, frame strobes (ball then barrier), scoring,
// level progression and the registered speed configuration.
module game_speed_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV     = 500000,
  parameter int LEVEL_PASSES = 8,
  parameter int MAX_LEVEL    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       collision,
  input  logic       barrier_passed,
  output logic       ball_step,
  output logic       barrier_step,
  output logic [3:0] barrier_speed,
  output logic [3:0] max_speed,
  output logic [1:0] level,
  output logic [7:0] score,
  output logic [1:0] state
);

  localparam int PW = $clog2(LEVEL_PASSES + 1);
  localparam logic [1:0] LEVEL_CAP = 2'(MAX_LEVEL);

  state_e        state_q, state_d;
  logic          start_prev_q, pause_prev_q;
  logic          start_rise_s, pause_rise_s;
  logic [1:0]    level_q, level_d;
  logic [7:0]    score_q, score_d;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d, pass_inc_s;
  logic          ball_step_q, ball_step_d;
  logic          barrier_step_q, barrier_step_d;
  logic [3:0]    barrier_speed_q, barrier_speed_d;
  logic [3:0]    max_speed_q, max_speed_d;
  logic          tick_s;

  assign start_rise_s = start_btn & ~start_prev_q;
  assign pause_rise_s = pause_btn & ~pause_prev_q;

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == ST_RUN),
    .hold  (state_q == ST_PAUSE),
    .clear ((state_q == ST_IDLE) || (state_q == ST_OVER)),
    .tick  (tick_s)
  );

  // Game FSM, score and level bookkeeping; collision outranks pause and passes
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    score_d    = score_q;
    pass_cnt_d = pass_cnt_q;
    pass_inc_s = pass_cnt_q + PW'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_rise_s) begin
          state_d    = ST_RUN;
          level_d    = 2'd0;
          score_d    = 8'd0;
          pass_cnt_d = {PW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (collision) begin
          state_d = ST_OVER;
        end else begin
          if (pause_rise_s) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
          if (barrier_passed) begin
            if (score_q != 8'd255) begin
              score_d = score_q + 8'd1;
            end else begin
              score_d = score_q;
            end
            if (pass_inc_s == PW'(LEVEL_PASSES)) begin
              pass_cnt_d = {PW{1'b0}};
              if (level_q < LEVEL_CAP) begin
                level_d = level_q + 2'd1;
              end else begin
                level_d = level_q;
              end
            end else begin
              pass_cnt_d = pass_inc_s;
            end
          end else begin
            pass_cnt_d = pass_cnt_q;
          end
        end
      end
      ST_PAUSE: begin
        if (pause_rise_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_OVER: begin
        if (start_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes only issue if the game is still running when they land; speeds track the committed level
  always_comb begin
    ball_step_d     = tick_s & (state_d == ST_RUN);
    barrier_step_d  = ball_step_q & (state_d == ST_RUN);
    barrier_speed_d = barrier_speed_for(level_q);
    max_speed_d     = max_speed_for(level_q);
  end

  // State, bookkeeping and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      start_prev_q    <= 1'b0;
      pause_prev_q    <= 1'b0;
      level_q         <= 2'd0;
      score_q         <= 8'd0;
      pass_cnt_q      <= {PW{1'b0}};
      ball_step_q     <= 1'b0;
      barrier_step_q  <= 1'b0;
      barrier_speed_q <= BARRIER_SPEED;
      max_speed_q     <= MAX_SPEED;
    end else begin
      state_q         <= state_d;
      start_prev_q    <= start_btn;
      pause_prev_q    <= pause_btn;
      level_q         <= level_d;
      score_q         <= score_d;
      pass_cnt_q      <= pass_cnt_d;
      ball_step_q     <= ball_step_d;
      barrier_step_q  <= barrier_step_d;
      barrier_speed_q <= barrier_speed_d;
      max_speed_q     <= max_speed_d;
    end
  end

  assign ball_step     = ball_step_q;
  assign barrier_step  = barrier_step_q;
  assign barrier_speed = barrier_speed_q;
  assign max_speed     = max_speed_q;
  assign level         = level_q;
  assign score         = score_q;
  assign state         = state_q;

endmodule

// File: tb/tb_game_speed_scheduler.sv
// Scoreboard bench for game_speed_scheduler. Stimulus pushes expected
// snapshots / strobes tagged with the observation cycle; monitors pop and
// compare as the DUT presents them.
module tb_game_speed_scheduler;

  localparam int TICK_DIV = 4, LEVEL_PASSES = 2, MAX_LEVEL = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_btn, pause_btn, collision, barrier_passed;
  logic ball_step, barrier_step;
  logic [3:0] barrier_speed, max_speed;
  logic [1:0] level, state;
  logic [7:0] score;

  always #5 clk = ~clk;

  game_speed_scheduler #(
    .TICK_DIV(TICK_DIV), .LEVEL_PASSES(LEVEL_PASSES), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .collision(collision), .barrier_passed(barrier_passed),
    .ball_step(ball_step), .barrier_step(barrier_step),
    .barrier_speed(barrier_speed), .max_speed(max_speed),
    .level(level), .score(score), .state(state)
  );

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [1:0] lvl;
    logic [7:0] sc;
    logic [3:0] bs;
    logic [3:0] ms;
  } snap_t;

  typedef struct {
    int cyc;
    bit kind;   // 0 = ball_step, 1 = barrier_step
  } strobe_t;

  snap_t   exp_q[$];
  snap_t   rst_q[$];
  strobe_t str_q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit strobe_chk = 1'b0;

  function automatic snap_t mk(input int c, input logic [1:0] st, input logic [1:0] lvl,
                               input logic [7:0] sc, input logic [3:0] bs, input logic [3:0] ms);
    snap_t s;
    s.cyc = c; s.st = st; s.lvl = lvl; s.sc = sc; s.bs = bs; s.ms = ms;
    return s;
  endfunction

  task automatic push_snap(input int c, input logic [1:0] st, input logic [1:0] lvl,
                           input logic [7:0] sc, input logic [3:0] bs, input logic [3:0] ms);
    exp_q.push_back(mk(c, st, lvl, sc, bs, ms));
  endtask

  task automatic push_strobe(input int c, input bit k);
    strobe_t s;
    s.cyc = c; s.kind = k;
    str_q.push_back(s);
  endtask

  task automatic cmp_snap(input string tag, input snap_t e);
    checks++;
    if (state !== e.st || level !== e.lvl || score !== e.sc ||
        barrier_speed !== e.bs || max_speed !== e.ms) begin
      failures++;
      $display("FAIL %s cyc=%0d got st=%0d lvl=%0d sc=%0d bs=%0d ms=%0d required st=%0d lvl=%0d sc=%0d bs=%0d ms=%0d",
               tag, cyc, state, level, score, barrier_speed, max_speed,
               e.st, e.lvl, e.sc, e.bs, e.ms);
    end
  endtask

  task automatic match_strobe(input bit k, input string name);
    int idx;
    idx = -1;
    for (int i = 0; i < str_q.size(); i++) begin
      if (str_q[i].cyc == cyc && str_q[i].kind == k) idx = i;
    end
    checks++;
    if (idx < 0) begin
      failures++;
      $display("FAIL %s_unexpected cyc=%0d got 1 required 0", name, cyc);
    end else begin
      str_q.delete(idx);
    end
  endtask

  // Synchronous monitor: observe registered outputs 1 time unit after each clock edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          cmp_snap("snap", exp_q[i]);
          exp_q.delete(i);
        end else if (exp_q[i].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL snap_missed cyc=%0d got none required at cyc=%0d", cyc, exp_q[i].cyc);
          exp_q.delete(i);
        end
      end
      if (strobe_chk) begin
        if (ball_step === 1'b1) match_strobe(1'b0, "ball_step");
        if (barrier_step === 1'b1) match_strobe(1'b1, "barrier_step");
      end
      for (int i = str_q.size() - 1; i >= 0; i--) begin
        if (str_q[i].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL strobe_missing kind=%0d got 0 required 1 at cyc=%0d", str_q[i].kind, str_q[i].cyc);
          str_q.delete(i);
        end
      end
    end
  end

  // Async-reset monitor: outputs must clear without waiting for a clock
  initial begin
    snap_t e;
    forever begin
      @(negedge reset);
      #1;
      if (rst_q.size() > 0) begin
        e = rst_q.pop_front();
        cmp_snap("async_reset", e);
        checks++;
        if (ball_step !== 1'b0 || barrier_step !== 1'b0) begin
          failures++;
          $display("FAIL async_reset_strobes got ball=%b barrier=%b required 0 0", ball_step, barrier_step);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  logic [1:0] lv_tab [0:8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [3:0] bs_tab [0:3] = '{4'd4, 4'd5, 4'd6, 4'd8};
  logic [3:0] ms_tab [0:3] = '{4'd7, 4'd7, 4'd9, 4'd9};

  // Directed stimulus; all inputs change on the falling edge
  initial begin
    int c, x, y, z;
    start_btn = 1'b0; pause_btn = 1'b0; collision = 1'b0; barrier_passed = 1'b0;
    #2;
    rst_q.push_back(mk(0, S_IDLE, 2'd0, 8'd0, 4'd4, 4'd7));
    reset = 1'b0;
    wait_cyc(2);
    c = cyc;
    push_snap(c + 1, S_IDLE, 2'd0, 8'd0, 4'd4, 4'd7);
    strobe_chk = 1'b1;
    wait_cyc(c + 2);
    reset = 1'b1;
    wait_cyc(c + 4);

    // Test 1: start -> RUN; ball every 4 cycles, barrier one cycle later
    c = cyc;
    start_btn = 1'b1;
    push_snap(c + 1, S_RUN, 2'd0, 8'd0, 4'd4, 4'd7);
    for (int k = 0; k < 3; k++) begin
      push_strobe(c + 5 + 4 * k, 1'b0);
      push_strobe(c + 6 + 4 * k, 1'b1);
    end
    wait_cyc(c + 1);
    start_btn = 1'b0;
    wait_cyc(c + 15);
    strobe_chk = 1'b0;

    // Test 2: 8 passes, level steps every 2, saturates at 3; speeds lag by one cycle
    for (int k = 1; k <= 8; k++) begin
      x = c + 16 + 3 * (k - 1);
      wait_cyc(x);
      barrier_passed = 1'b1;
      push_snap(x + 1, S_RUN, lv_tab[k], 8'(k), bs_tab[lv_tab[k-1]], ms_tab[lv_tab[k-1]]);
      push_snap(x + 2, S_RUN, lv_tab[k], 8'(k), bs_tab[lv_tab[k]], ms_tab[lv_tab[k]]);
      wait_cyc(x + 1);
      barrier_passed = 1'b0;
    end

    // Test 3: RUN began at c+1, so counter reads 1 at y=c+42 and holds 2 in PAUSE
    y = c + 42;
    wait_cyc(y);
    pause_btn = 1'b1;
    strobe_chk = 1'b1;
    push_snap(y + 1, S_PAUSE, 2'd3, 8'd8, 4'd8, 4'd9);
    wait_cyc(y + 1);
    pause_btn = 1'b0;
    wait_cyc(y + 5);
    barrier_passed = 1'b1;
    push_snap(y + 7, S_PAUSE, 2'd3, 8'd8, 4'd8, 4'd9);
    wait_cyc(y + 6);
    barrier_passed = 1'b0;
    wait_cyc(y + 21);
    pause_btn = 1'b1;
    push_snap(y + 22, S_RUN, 2'd3, 8'd8, 4'd8, 4'd9);
    push_strobe(y + 24, 1'b0);
    push_strobe(y + 25, 1'b1);
    push_strobe(y + 28, 1'b0);
    wait_cyc(y + 22);
    pause_btn = 1'b0;

    // Test 4: collision + pause rise + pass while ball_step is high
    wait_cyc(y + 28);
    collision = 1'b1; pause_btn = 1'b1; barrier_passed = 1'b1;
    push_snap(y + 29, S_OVER, 2'd3, 8'd8, 4'd8, 4'd9);
    wait_cyc(y + 29);
    collision = 1'b0; pause_btn = 1'b0; barrier_passed = 1'b0;
    wait_cyc(y + 33);
    strobe_chk = 1'b0;

    // Set up OVER with score 5 / level 2
    z = y + 34;
    wait_cyc(z);
    start_btn = 1'b1;
    push_snap(z + 1, S_IDLE, 2'd3, 8'd8, 4'd8, 4'd9);
    wait_cyc(z + 1);
    start_btn = 1'b0;
    wait_cyc(z + 3);
    start_btn = 1'b1;
    push_snap(z + 4, S_RUN, 2'd0, 8'd0, 4'd8, 4'd9);
    push_snap(z + 5, S_RUN, 2'd0, 8'd0, 4'd4, 4'd7);
    wait_cyc(z + 4);
    start_btn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_cyc(z + 6 + 3 * k);
      barrier_passed = 1'b1;
      wait_cyc(z + 7 + 3 * k);
      barrier_passed = 1'b0;
    end
    push_snap(z + 20, S_RUN, 2'd2, 8'd5, 4'd6, 4'd9);
    wait_cyc(z + 22);
    collision = 1'b1;
    push_snap(z + 23, S_OVER, 2'd2, 8'd5, 4'd6, 4'd9);
    wait_cyc(z + 23);
    collision = 1'b0;

    // Test 5: OVER -> IDLE holds 5/2, then IDLE -> RUN clears
    wait_cyc(z + 25);
    start_btn = 1'b1;
    push_snap(z + 26, S_IDLE, 2'd2, 8'd5, 4'd6, 4'd9);
    wait_cyc(z + 26);
    start_btn = 1'b0;
    wait_cyc(z + 28);
    start_btn = 1'b1;
    push_snap(z + 29, S_RUN, 2'd0, 8'd0, 4'd6, 4'd9);
    push_snap(z + 30, S_RUN, 2'd0, 8'd0, 4'd4, 4'd7);
    wait_cyc(z + 29);
    start_btn = 1'b0;
    strobe_chk = 1'b1;
    push_strobe(z + 33, 1'b0);

    // Test 6: reset between ball_step and barrier_step
    wait_cyc(z + 33);
    rst_q.push_back(mk(0, S_IDLE, 2'd0, 8'd0, 4'd4, 4'd7));
    push_snap(z + 34, S_IDLE, 2'd0, 8'd0, 4'd4, 4'd7);
    reset = 1'b0;
    wait_cyc(z + 37);
    reset = 1'b1;
    push_snap(z + 39, S_IDLE, 2'd0, 8'd0, 4'd4, 4'd7);
    wait_cyc(z + 41);
    strobe_chk = 1'b0;

    checks++;
    if (exp_q.size() != 0 || str_q.size() != 0 || rst_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got snap=%0d strobe=%0d rst=%0d required 0 0 0",
               exp_q.size(), str_q.size(), rst_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-length bound
  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
